vcache_stat_collector: RTL and testbench
========================================

# vcache_stat_collector

Synthesizable, parametrised statistics unit for banks of vcaches. It is the next generation of the testbench-only vcache profiler. Per bank it keeps saturating event counters for loads, stores, load misses, store misses and miss-stall cycles. On request it snapshots all counters atomically and streams them out over a valid/yumi interface, so the numbers can be read from a host or a trace unit instead of via `$fwrite`.

## Interface
Parameters:
- `num_banks_p`, 1: number of vcache banks monitored, 1..32.
- `counter_width_p`, 32: width of each counter and of `stat_data_o`.
- `tag_width_p`, 32: width of the snapshot tag.
- `clear_on_snapshot_p`, 0: if 1, live counters are cleared when a snapshot is accepted.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `v_o_i` in `num_banks_p`: bank response valid.
- `yumi_i` in `num_banks_p`: bank response consumed.
- `v_v_r_i` in `num_banks_p`: verify stage holds a valid request.
- `miss_v_i` in `num_banks_p`: verify-stage request missed.
- `ld_op_i` in `num_banks_p`: verify-stage op is a load.
- `st_op_i` in `num_banks_p`: verify-stage op is a store.
- `global_ctr_i` in 32: free-running global timestamp.
- `snapshot_v_i` in 1: snapshot request.
- `snapshot_tag_i` in `tag_width_p`: user tag attached to the snapshot.
- `snapshot_ready_o` out 1: high when a snapshot can be accepted (FSM in IDLE).
- `stat_v_o` out 1: output beat valid.
- `stat_data_o` out `counter_width_p`: counter value.
- `stat_bank_o` out `max(1,$clog2(num_banks_p))`: bank index.
- `stat_event_o` out 3: event id, of type `vcache_stat_event_e`.
- `stat_tag_o` out `tag_width_p`: tag latched at snapshot.
- `stat_global_ctr_o` out 32: `global_ctr_i` latched at snapshot.
- `stat_last_o` out 1: final beat of a snapshot.
- `stat_yumi_i` in 1: consumer accepts the current beat.

## Operation
Per-bank events, all evaluated in the same cycle:
- LD: `v_o_i & yumi_i & ld_op_i`
- ST: `v_o_i & yumi_i & st_op_i`
- LD_MISS: LD `& miss_v_i`
- ST_MISS: ST `& miss_v_i`
- MISS_STALL: `v_v_r_i & miss_v_i & ~(v_o_i | yumi_i)`

Counter rules:
- Each event adds 1 to its counter.
- Counters saturate at all-ones and never wrap.

FSM states IDLE and SEND:
- IDLE to SEND on `snapshot_v_i & snapshot_ready_o`. In that cycle:
  - every live counter value, including that cycle's increment, is copied into the shadow registers;
  - the tag and `global_ctr_i` are latched;
  - the beat index is set to 0.
- SEND emits `num_banks_p*5` beats. Order is bank-major: bank 0 events 0..4, then bank 1, and so on.
- The beat index advances on `stat_yumi_i & stat_v_o`.
- SEND to IDLE on yumi of the beat with `stat_last_o=1`.
- Live counters keep counting throughout SEND and are unaffected by readout.
- `snapshot_v_i` while not ready is ignored; there is no queuing.
- `stat_yumi_i` while `stat_v_o=0` is ignored.
- `clear_on_snapshot_p=1`: at acceptance each live counter becomes 1 if its event fires that cycle, else 0. The shadow still captures the pre-clear value plus that cycle's event.

## Timing
- Outputs after reset:
  - `stat_v_o=0`, `stat_last_o=0`, `snapshot_ready_o=1`;
  - `stat_data_o`, `stat_bank_o`, `stat_event_o`, `stat_tag_o` and `stat_global_ctr_o` all 0;
  - all live and shadow counters 0.
- Snapshot accepted at cycle t gives the first beat valid at t+1.
- Each beat can complete in 1 cycle with `stat_yumi_i` held high, so a full snapshot takes `num_banks_p*5` cycles.
- `snapshot_ready_o` rises in the cycle after the last yumi. Back-to-back snapshots are therefore one cycle apart at best.
- Beat outputs are registered or shadow-selected and stay stable while `stat_v_o & ~stat_yumi_i`.
- `reset_i` during SEND aborts the stream. Next cycle: `stat_v_o=0`, state IDLE, counters 0.

## Structure
- Package `vcache_stat_pkg` holds:
  - enum `vcache_stat_event_e` (3 bits): LD=0, ST=1, LD_MISS=2, ST_MISS=3, MISS_STALL=4;
  - `vcache_stat_num_events_gp=5`;
  - the FSM state enum.
- Sub-module `vcache_sat_counter #(width_p)` takes `clk_i`, `reset_i`, `clear_i`, `inc_i` and outputs `count_o`. `clear_i & inc_i` yields 1.
- The top instantiates `num_banks_p*5` of these counters, plus the shadow array, FSM and output mux.

## Test plan
- Single bank. Drive 3 LD hits, 2 ST hits, 1 LD miss with 4 stall cycles, then snapshot with tag 0xA5. Expect 5 beats: 4, 2, 1, 0, 4. Tag 0xA5 on every beat; `stat_last_o` on beat 5 only.
- `counter_width_p=4`. Drive 20 LD events. Expect LD=15 (saturated) and no wrap.
- `num_banks_p=4`, `clear_on_snapshot_p=1`. Bank 2 fires LD in the acceptance cycle after 7 prior LDs. Expect bank 2 LD shadow = 8, then a second snapshot reports 1 plus any later LDs. Expect 20 beats per snapshot in bank-major order.
- Assert `snapshot_v_i` during SEND. Expect it ignored, `snapshot_ready_o=0`, and no stream corruption.
- Toggle `stat_yumi_i` randomly with 50% stalls. Expect beat data stable during stalls and events counted during SEND absent from the current snapshot but present in the next.
- Assert `reset_i` at beat 3 of SEND. Expect `stat_v_o=0` and `snapshot_ready_o=1` next cycle, and the next snapshot reads all zeros.

Source files
------------

// File: rtl/vcache_stat_pkg.sv
// vcache_stat_pkg: event ids, event count and FSM states shared by the vcache statistics collector
package vcache_stat_pkg;

   localparam int vcache_stat_num_events_gp = 5;

   typedef enum logic [2:0] {
      e_ld         = 3'd0,
      e_st         = 3'd1,
      e_ld_miss    = 3'd2,
      e_st_miss    = 3'd3,
      e_miss_stall = 3'd4
   } vcache_stat_event_e;

   typedef enum logic {
      e_idle = 1'b0,
      e_send = 1'b1
   } vcache_stat_state_e;

endpackage

// File: rtl/vcache_sat_counter.sv
// vcache_sat_counter: saturating event counter; a clear coinciding with an increment restarts at 1
module vcache_sat_counter #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] r_count;

   always_ff @(posedge clk_i) begin
      if (reset_i) r_count <= '0;
      else if (clear_i) r_count <= width_p'(inc_i);
      else if (inc_i & ~&r_count) r_count <= r_count + width_p'(1);
   end

   assign count_o = r_count;

endmodule

// File: rtl/vcache_stat_collector.sv
// vcache_stat_collector: per-bank saturating vcache event counters with atomic snapshot and
// bank-major valid/yumi readout of the shadow copy
module vcache_stat_collector
   import vcache_stat_pkg::*;
#(
   parameter int num_banks_p         = 1,
   parameter int counter_width_p     = 32,
   parameter int tag_width_p         = 32,
   parameter int clear_on_snapshot_p = 0,
   localparam int bank_width_lp      = (num_banks_p > 1) ? $clog2(num_banks_p) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [num_banks_p-1:0]     v_o_i,
   input  logic [num_banks_p-1:0]     yumi_i,
   input  logic [num_banks_p-1:0]     v_v_r_i,
   input  logic [num_banks_p-1:0]     miss_v_i,
   input  logic [num_banks_p-1:0]     ld_op_i,
   input  logic [num_banks_p-1:0]     st_op_i,
   input  logic [31:0]                global_ctr_i,
   input  logic                       snapshot_v_i,
   input  logic [tag_width_p-1:0]     snapshot_tag_i,
   output logic                       snapshot_ready_o,
   output logic                       stat_v_o,
   output logic [counter_width_p-1:0] stat_data_o,
   output logic [bank_width_lp-1:0]   stat_bank_o,
   output vcache_stat_event_e         stat_event_o,
   output logic [tag_width_p-1:0]     stat_tag_o,
   output logic [31:0]                stat_global_ctr_o,
   output logic                       stat_last_o,
   input  logic                       stat_yumi_i
);

   localparam int ne_lp = vcache_stat_num_events_gp;

   logic [ne_lp-1:0]           w_ev     [num_banks_p];
   logic [counter_width_p-1:0] w_cnt    [num_banks_p][ne_lp];
   logic [counter_width_p-1:0] w_snap   [num_banks_p][ne_lp];
   logic [counter_width_p-1:0] r_shadow [num_banks_p][ne_lp];
   logic [num_banks_p-1:0]     w_hs;
   logic                       w_accept, w_beat_done, w_clear;
   logic [bank_width_lp-1:0]   r_bank;
   vcache_stat_event_e         r_ev;
   logic [tag_width_p-1:0]     r_tag;
   logic [31:0]                r_gctr;
   vcache_stat_state_e         r_state, w_state_n;

   assign w_hs    = v_o_i & yumi_i;
   assign w_clear = (clear_on_snapshot_p != 0) & w_accept;

   for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
      assign w_ev[b] = {v_v_r_i[b] & miss_v_i[b] & ~(v_o_i[b] | yumi_i[b]),
                        w_hs[b] & st_op_i[b] & miss_v_i[b],
                        w_hs[b] & ld_op_i[b] & miss_v_i[b],
                        w_hs[b] & st_op_i[b],
                        w_hs[b] & ld_op_i[b]};
      for (genvar e = 0; e < ne_lp; e++) begin : g_ev
         vcache_sat_counter #(.width_p(counter_width_p)) u_ctr (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clear_i (w_clear),
            .inc_i   (w_ev[b][e]),
            .count_o (w_cnt[b][e])
         );
         // The snapshot must include this cycle's event, so mirror the counter's next value
         assign w_snap[b][e] = (w_ev[b][e] & ~&w_cnt[b][e]) ? w_cnt[b][e] + counter_width_p'(1) : w_cnt[b][e];
      end
   end

   always_ff @(posedge clk_i) begin
      r_state <= reset_i ? e_idle : w_state_n;
   end

   always_comb begin
      snapshot_ready_o = (r_state == e_idle);
      stat_v_o         = (r_state == e_send);
      w_accept         = snapshot_ready_o & snapshot_v_i;
      w_beat_done      = stat_v_o & stat_yumi_i;
      stat_last_o      = stat_v_o & (r_bank == bank_width_lp'(num_banks_p - 1)) & (r_ev == e_miss_stall);
      w_state_n        = w_accept ? e_send : (w_beat_done & stat_last_o) ? e_idle : r_state;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_shadow <= '{default: '0};
         r_bank   <= '0;
         r_ev     <= e_ld;
         r_tag    <= '0;
         r_gctr   <= '0;
      end else if (w_accept) begin
         r_shadow <= w_snap;
         r_bank   <= '0;
         r_ev     <= e_ld;
         r_tag    <= snapshot_tag_i;
         r_gctr   <= global_ctr_i;
      end else if (w_beat_done) begin
         r_ev   <= (r_ev == e_miss_stall) ? e_ld : vcache_stat_event_e'(r_ev + 3'd1);
         r_bank <= stat_last_o ? '0 : (r_ev == e_miss_stall) ? r_bank + bank_width_lp'(1) : r_bank;
      end
   end

   assign stat_data_o       = r_shadow[r_bank][r_ev];
   assign stat_bank_o       = r_bank;
   assign stat_event_o      = r_ev;
   assign stat_tag_o        = r_tag;
   assign stat_global_ctr_o = r_gctr;

endmodule

// File: tb/tb_vcache_stat_collector.sv
// tb_vcache_stat_collector: two collectors (4-bit no-clear, 8-bit clear-on-snapshot) on shared
// stimulus, checked cycle by cycle against an arithmetic model of counts and snapshot streams
module tb_vcache_stat_collector;
   import vcache_stat_pkg::*;

   localparam int NB = 4, NE = 5, NBEAT = NB * NE;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic [NB-1:0] v_o_i = '0, yumi_i = '0, v_v_r_i = '0, miss_v_i = '0, ld_op_i = '0, st_op_i = '0;
   logic [31:0] gctr = '0, snap_tag = '0;
   logic        snap_v = 1'b0, syumi = 1'b0;

   logic a_ready, a_v, a_last, b_ready, b_v, b_last;
   logic [3:0] a_data;
   logic [7:0] b_data;
   logic [1:0] a_bank, b_bank;
   vcache_stat_event_e a_ev, b_ev;
   logic [31:0] a_tag, a_g, b_tag, b_g;

   vcache_stat_collector #(.num_banks_p(NB), .counter_width_p(4), .tag_width_p(32), .clear_on_snapshot_p(0)) u_dut_a (
      .clk_i(clk), .reset_i(reset_i), .v_o_i(v_o_i), .yumi_i(yumi_i), .v_v_r_i(v_v_r_i),
      .miss_v_i(miss_v_i), .ld_op_i(ld_op_i), .st_op_i(st_op_i), .global_ctr_i(gctr),
      .snapshot_v_i(snap_v), .snapshot_tag_i(snap_tag), .snapshot_ready_o(a_ready),
      .stat_v_o(a_v), .stat_data_o(a_data), .stat_bank_o(a_bank), .stat_event_o(a_ev),
      .stat_tag_o(a_tag), .stat_global_ctr_o(a_g), .stat_last_o(a_last), .stat_yumi_i(syumi));

   vcache_stat_collector #(.num_banks_p(NB), .counter_width_p(8), .tag_width_p(32), .clear_on_snapshot_p(1)) u_dut_b (
      .clk_i(clk), .reset_i(reset_i), .v_o_i(v_o_i), .yumi_i(yumi_i), .v_v_r_i(v_v_r_i),
      .miss_v_i(miss_v_i), .ld_op_i(ld_op_i), .st_op_i(st_op_i), .global_ctr_i(gctr),
      .snapshot_v_i(snap_v), .snapshot_tag_i(snap_tag), .snapshot_ready_o(b_ready),
      .stat_v_o(b_v), .stat_data_o(b_data), .stat_bank_o(b_bank), .stat_event_o(b_ev),
      .stat_tag_o(b_tag), .stat_global_ctr_o(b_g), .stat_last_o(b_last), .stat_yumi_i(syumi));

   always #5 clk = ~clk;

   int live [2][NB][NE];
   int snap [2][NB][NE];
   int obs  [2][NBEAT];
   int maxv [2] = '{15, 255};
   bit clr  [2] = '{1'b0, 1'b1};
   bit m_send;
   int m_idx;
   logic [31:0] m_tag, m_g;
   int n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++)
         for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++) begin
               live[i][b][e] = 0;
               snap[i][b][e] = 0;
            end
      m_send = 0;
      m_idx  = 0;
   endtask

   task automatic tick();
      int ev [NB][NE];
      bit acc, hs;
      int s;
      check("a_v", a_v, m_send);
      check("b_v", b_v, m_send);
      check("a_ready", a_ready, !m_send);
      check("b_ready", b_ready, !m_send);
      if (m_send) begin
         int bk, e;
         bk = m_idx / NE;
         e  = m_idx % NE;
         check("a_data", a_data, snap[0][bk][e]);
         check("b_data", b_data, snap[1][bk][e]);
         check("a_bank", a_bank, bk);
         check("b_bank", b_bank, bk);
         check("a_event", a_ev, e);
         check("b_event", b_ev, e);
         check("a_tag", a_tag, m_tag);
         check("b_tag", b_tag, m_tag);
         check("a_gctr", a_g, m_g);
         check("b_gctr", b_g, m_g);
         check("a_last", a_last, m_idx == NBEAT - 1);
         check("b_last", b_last, m_idx == NBEAT - 1);
         if (syumi) begin
            obs[0][m_idx] = int'(a_data);
            obs[1][m_idx] = int'(b_data);
         end
      end
      if (reset_i) model_clear();
      else begin
         for (int b = 0; b < NB; b++) begin
            ev[b][0] = int'(v_o_i[b] && yumi_i[b] && ld_op_i[b]);
            ev[b][1] = int'(v_o_i[b] && yumi_i[b] && st_op_i[b]);
            ev[b][2] = int'(v_o_i[b] && yumi_i[b] && ld_op_i[b] && miss_v_i[b]);
            ev[b][3] = int'(v_o_i[b] && yumi_i[b] && st_op_i[b] && miss_v_i[b]);
            ev[b][4] = int'(v_v_r_i[b] && miss_v_i[b] && !(v_o_i[b] || yumi_i[b]));
         end
         acc = !m_send && snap_v;
         hs  = m_send && syumi;
         for (int i = 0; i < 2; i++)
            for (int b = 0; b < NB; b++)
               for (int e = 0; e < NE; e++) begin
                  s = live[i][b][e] + ev[b][e];
                  if (s > maxv[i]) s = maxv[i];
                  if (acc) snap[i][b][e] = s;
                  live[i][b][e] = (acc && clr[i]) ? ev[b][e] : s;
               end
         if (acc) begin
            m_send = 1;
            m_idx  = 0;
            m_tag  = snap_tag;
            m_g    = gctr;
         end else if (hs) begin
            if (m_idx == NBEAT - 1) m_send = 0;
            else m_idx++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // kind: 0 none, 1 load hit, 2 store hit, 3 load miss, 4 miss stall
   task automatic set_ev(input int b, input int kind);
      v_o_i = '0; yumi_i = '0; v_v_r_i = '0; miss_v_i = '0; ld_op_i = '0; st_op_i = '0;
      gctr = $urandom;
      if (kind inside {1, 2, 3}) begin
         v_o_i[b] = 1'b1;
         yumi_i[b] = 1'b1;
         v_v_r_i[b] = 1'b1;
      end
      if (kind == 1 || kind == 3) ld_op_i[b] = 1'b1;
      if (kind == 2) st_op_i[b] = 1'b1;
      if (kind == 3 || kind == 4) miss_v_i[b] = 1'b1;
      if (kind == 4) begin
         v_v_r_i[b] = 1'b1;
         ld_op_i[b] = 1'b1;
      end
   endtask

   task automatic set_rand();
      v_o_i = NB'($urandom); yumi_i = NB'($urandom); v_v_r_i = NB'($urandom);
      miss_v_i = NB'($urandom); ld_op_i = NB'($urandom); st_op_i = NB'($urandom);
      gctr = $urandom;
   endtask

   task automatic start_snapshot(input logic [31:0] tag);
      set_ev(0, 0);
      snap_tag = tag;
      snap_v = 1'b1;
      syumi = 1'b1;
      tick();
      snap_v = 1'b0;
   endtask

   task automatic drain();
      while (m_send) begin
         set_ev(0, 0);
         syumi = 1'b1;
         tick();
      end
   endtask

   initial begin
      int sum_a, sum_b;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;
      check("rst_a_v", a_v, 0);
      check("rst_a_ready", a_ready, 1);
      check("rst_a_last", a_last, 0);
      check("rst_a_data", a_data, 0);
      check("rst_a_bank", a_bank, 0);
      check("rst_a_event", a_ev, 0);
      check("rst_a_tag", a_tag, 0);
      check("rst_a_gctr", a_g, 0);
      check("rst_b_data", b_data, 0);

      repeat (3) begin set_ev(0, 1); tick(); end
      repeat (2) begin set_ev(0, 2); tick(); end
      set_ev(0, 3); tick();
      repeat (4) begin set_ev(0, 4); tick(); end
      start_snapshot(32'hA5);
      drain();
      for (int i = 0; i < 2; i++) begin
         check("dir_ld", obs[i][0], 4);
         check("dir_st", obs[i][1], 2);
         check("dir_ld_miss", obs[i][2], 1);
         check("dir_st_miss", obs[i][3], 0);
         check("dir_stall", obs[i][4], 4);
      end

      repeat (20) begin set_ev(1, 1); tick(); end
      start_snapshot(32'h1234);
      drain();
      check("sat_a_ld", obs[0][5], 15);
      check("sat_b_ld", obs[1][5], 20);

      repeat (7) begin set_ev(2, 1); tick(); end
      set_ev(2, 1);
      snap_tag = 32'h77;
      snap_v = 1'b1;
      syumi = 1'b1;
      tick();
      snap_v = 1'b0;
      drain();
      check("clr1_a_ld", obs[0][10], 8);
      check("clr1_b_ld", obs[1][10], 8);
      start_snapshot(32'h78);
      drain();
      check("clr2_a_ld", obs[0][10], 8);
      check("clr2_b_ld", obs[1][10], 1);

      start_snapshot(32'hBEEF);
      while (m_send) begin
         set_rand();
         snap_v = 1'b1;
         snap_tag = $urandom;
         syumi = 1'($urandom);
         tick();
      end
      snap_v = 1'b0;

      repeat (2500) begin
         set_rand();
         snap_v = ($urandom_range(0, 7) == 0);
         snap_tag = $urandom;
         syumi = 1'($urandom);
         tick();
      end
      snap_v = 1'b0;
      drain();

      start_snapshot(32'hC0DE);
      repeat (3) begin set_rand(); syumi = 1'b1; tick(); end
      set_ev(0, 0);
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      check("abort_a_v", a_v, 0);
      check("abort_a_ready", a_ready, 1);
      check("abort_b_v", b_v, 0);
      start_snapshot(32'hD00D);
      drain();
      sum_a = 0;
      sum_b = 0;
      for (int i = 0; i < NBEAT; i++) begin
         sum_a += obs[0][i];
         sum_b += obs[1][i];
      end
      check("abort_a_zero", sum_a, 0);
      check("abort_b_zero", sum_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
